// File: rtl/config_frame_sequencer_pkg.sv
// Purpose: shared types and header layout for the configuration frame sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional build macro CFG_FRAME_CHECKSUM_EN adds the CHK state.
package config_frame_sequencer_pkg;

  // Header word layout: [31:24] magic, [23:16] column, [15:8] frame, [7:0] ignored.
  localparam logic [7:0] HdrMagic    = 8'hFA;
  localparam int         HdrFieldW   = 8;
  localparam int         HdrMagicLsb = 24;
  localparam int         HdrColLsb   = 16;
  localparam int         HdrFrameLsb = 8;

`ifdef CFG_FRAME_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_HDR, ST_DATA, ST_CHK, ST_STROBE, ST_DISCARD
  } seq_state_e;
`else
  typedef enum logic [2:0] {
    ST_HDR, ST_DATA, ST_STROBE, ST_DISCARD
  } seq_state_e;
`endif

endpackage

// File: rtl/config_frame_sequencer_hdr_decode.sv
// Purpose: combinational header check (magic + column/frame range) and field extract.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller qualifies with its own handshake.
// Ports: hdr_hi = header bits [31:8]; magic_ok, range_ok flags; col, frame fields.
module config_frame_hdr_decode
  import config_frame_sequencer_pkg::*;
#(
  parameter int NumColumns      = 16,
  parameter int MaxFramesPerCol = 20
) (
  input  logic [31:8] hdr_hi,
  output logic        magic_ok,
  output logic        range_ok,
  output logic [7:0]  col,
  output logic [7:0]  frame
);

  always_comb begin
    col      = hdr_hi[HdrColLsb   +: HdrFieldW];
    frame    = hdr_hi[HdrFrameLsb +: HdrFieldW];
    magic_ok = (hdr_hi[HdrMagicLsb +: HdrFieldW] == HdrMagic);
    range_ok = (int'(col) < NumColumns) && (int'(frame) < MaxFramesPerCol);
  end

endmodule

// File: rtl/config_frame_sequencer.sv
// Purpose: turns a header+data word stream into one-hot column/frame write strobes.
// Latency: header accept to strobe = NumRows+1 cycles (NumRows+2 with CFG_FRAME_CHECKSUM_EN).
// Backpressure: s_ready low only in reset and the single STROBE cycle; s_valid low stalls.
// Ports: CLK/resetn; s_data/s_valid/s_ready stream in; FrameData, FrameStrobe, ColSelect
//        to the fabric; frames_done count, sticky cfg_err, busy (not in HDR).
module config_frame_sequencer
  import config_frame_sequencer_pkg::*;
#(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NumRows         = 8,
  parameter int NumColumns      = 16
) (
  input  logic                               CLK,
  input  logic                               resetn,
  input  logic [31:0]                        s_data,
  input  logic                               s_valid,
  output logic                               s_ready,
  output logic [NumRows*FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]         FrameStrobe,
  output logic [NumColumns-1:0]              ColSelect,
  output logic [15:0]                        frames_done,
  output logic                               cfg_err,
  output logic                               busy
);

  // Counter is shared by DATA (row index) and DISCARD (words dropped).
  localparam int RowW = $clog2(NumRows + 2);
  localparam logic [RowW-1:0] LastRow = RowW'(NumRows - 1);
`ifdef CFG_FRAME_CHECKSUM_EN
  localparam logic [RowW-1:0] DiscardLast = RowW'(NumRows);
`else
  localparam logic [RowW-1:0] DiscardLast = RowW'(NumRows - 1);
`endif

  seq_state_e                         state_q, state_d;
  logic [RowW-1:0]                    row_q, row_d;
  logic [7:0]                         col_q, col_d;
  logic [7:0]                         frame_q, frame_d;
  logic [NumRows*FrameBitsPerRow-1:0] frame_data_q, frame_data_d;
  logic [15:0]                        frames_done_q, frames_done_d;
  logic                               cfg_err_q, cfg_err_d;
  logic                               rdy_en_q;
`ifdef CFG_FRAME_CHECKSUM_EN
  logic [31:0]                        chk_q, chk_d;
`endif

  logic       hdr_magic_ok, hdr_range_ok;
  logic [7:0] hdr_col, hdr_frame;
  logic       accept;

  config_frame_hdr_decode #(
    .NumColumns      (NumColumns),
    .MaxFramesPerCol (MaxFramesPerCol)
  ) u_hdr_decode (
    .hdr_hi   (s_data[31:8]),
    .magic_ok (hdr_magic_ok),
    .range_ok (hdr_range_ok),
    .col      (hdr_col),
    .frame    (hdr_frame)
  );

  assign accept = s_valid && s_ready;

  // State register.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) state_q <= ST_HDR;
    else         state_q <= state_d;
  end

  // Datapath registers. rdy_en_q holds s_ready low until the first edge after reset.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      row_q         <= '0;
      col_q         <= '0;
      frame_q       <= '0;
      frame_data_q  <= '0;
      frames_done_q <= '0;
      cfg_err_q     <= 1'b0;
      rdy_en_q      <= 1'b0;
`ifdef CFG_FRAME_CHECKSUM_EN
      chk_q         <= '0;
`endif
    end else begin
      row_q         <= row_d;
      col_q         <= col_d;
      frame_q       <= frame_d;
      frame_data_q  <= frame_data_d;
      frames_done_q <= frames_done_d;
      cfg_err_q     <= cfg_err_d;
      rdy_en_q      <= 1'b1;
`ifdef CFG_FRAME_CHECKSUM_EN
      chk_q         <= chk_d;
`endif
    end
  end

  // Next-state and datapath updates. Every transition except STROBE waits on accept.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    frame_d       = frame_q;
    frame_data_d  = frame_data_q;
    frames_done_d = frames_done_q;
    cfg_err_d     = cfg_err_q;
`ifdef CFG_FRAME_CHECKSUM_EN
    chk_d         = chk_q;
`endif
    unique case (state_q)
      ST_HDR: if (accept) begin
        row_d = '0;
        if (!hdr_magic_ok) begin
          cfg_err_d = 1'b1;
        end else if (!hdr_range_ok) begin
          cfg_err_d = 1'b1;
          state_d   = ST_DISCARD;
        end else begin
          col_d   = hdr_col;
          frame_d = hdr_frame;
          state_d = ST_DATA;
`ifdef CFG_FRAME_CHECKSUM_EN
          chk_d   = '0;
`endif
        end
      end
      ST_DATA: if (accept) begin
        frame_data_d[int'(row_q)*FrameBitsPerRow +: FrameBitsPerRow] = FrameBitsPerRow'(s_data);
        row_d = row_q + 1'b1;
`ifdef CFG_FRAME_CHECKSUM_EN
        chk_d = chk_q ^ s_data;
`endif
        if (row_q == LastRow) begin
          row_d = '0;
`ifdef CFG_FRAME_CHECKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_STROBE;
`endif
        end
      end
`ifdef CFG_FRAME_CHECKSUM_EN
      ST_CHK: if (accept) begin
        if (s_data == chk_q) begin
          state_d = ST_STROBE;
        end else begin
          cfg_err_d = 1'b1;
          state_d   = ST_HDR;
        end
      end
`endif
      ST_STROBE: begin
        frames_done_d = frames_done_q + 16'd1;
        state_d       = ST_HDR;
      end
      ST_DISCARD: if (accept) begin
        row_d = row_q + 1'b1;
        if (row_q == DiscardLast) begin
          row_d   = '0;
          state_d = ST_HDR;
        end
      end
      default: state_d = ST_HDR;
    endcase
  end

  // Outputs.
  always_comb begin
    s_ready     = rdy_en_q && (state_q != ST_STROBE);
    busy        = (state_q != ST_HDR);
    FrameData   = frame_data_q;
    frames_done = frames_done_q;
    cfg_err     = cfg_err_q;
    for (int i = 0; i < MaxFramesPerCol; i++) begin
      FrameStrobe[i] = (state_q == ST_STROBE) && (int'(frame_q) == i);
    end
    for (int i = 0; i < NumColumns; i++) begin
      ColSelect[i] = (state_q == ST_STROBE) && (int'(col_q) == i);
    end
  end

endmodule
